cdm16_mem_arbiter: RTL and testbench
====================================

Name: cdm16_mem_arbiter

Overview:
- Shares the single-port 15-bit word-addressed program/data BRAM between the cdm16 CPU port and a debug/loader port.
- The debug port is driven from the GPIO control path.
- Normally passes CPU accesses straight through to memory.
- On a debug request it stalls the CPU via hold, waits for a CPU bus gap, performs one debug word/byte access, then returns the bus with a guaranteed CPU-only cooldown window.

Parameters:
- ADDR_W, 15, memory word-address width.
- DATA_W, 16, memory data width.
- MIN_CPU_CYCLES, 4, cycles after a debug access during which new debug requests are ignored. 0 = no cooldown.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU memory cycle active (cdm_mem).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_we  in  2  CPU byte write enables [1]=high byte, [0]=low byte.
- cpu_wdata  in  DATA_W  CPU write data, already lane-aligned.
- cpu_rdata  out  DATA_W  read data to CPU; always equals mem_in.
- cpu_hold  out  1  stall request to CPU (cdm_in_hold).
- dbg_req  in  1  debug request level; held until dbg_ack.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_we  in  2  debug byte write enables; 2'b00 = read.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle completion pulse, registered.
- dbg_rdata  out  DATA_W  registered debug read data; valid when dbg_ack=1.
- mem_addr  out  ADDR_W  to BRAM.
- mem_out  out  DATA_W  BRAM write data.
- mem_in  in  DATA_W  BRAM read data; 1-cycle synchronous read latency.
- mem_en  out  1  BRAM enable.
- mem_write  out  2  BRAM byte write enables.

Behaviour:
- States: CPU, HOLD, DACC, DRESP. Reset -> CPU.
- Reset values: cpu_hold=0, dbg_ack=0, dbg_rdata=0, cooldown counter=0, captured debug regs=0.
- While reset=1: mem_en=0 and mem_write=0 regardless of state.
- Reset mid-debug: access aborted, no dbg_ack.
- CPU state:
  - mem_* = cpu_* combinationally: mem_en=cpu_req, mem_write=cpu_we & {2{cpu_req}}.
  - cpu_hold=0.
  - If dbg_req=1 and cooldown=0: capture dbg_addr/dbg_we/dbg_wdata, go to HOLD.
  - The CPU access in the same cycle completes normally; debug never preempts a presented CPU cycle.
  - If cooldown!=0: decrement and ignore dbg_req.
- HOLD:
  - cpu_hold=1, mem_en=0, mem_write=0.
  - Sample cpu_req each cycle; cpu_req=0 -> DACC, else stay.
  - No timeout.
- DACC:
  - cpu_hold=1, mem_en=1, mem_addr/mem_out/mem_write from captured debug regs.
  - Always -> DRESP.
- DRESP:
  - cpu_hold=1, mem_en=0, mem_write=0.
  - If captured we==0: dbg_rdata<=mem_in at the edge. Writes leave dbg_rdata unchanged.
  - dbg_ack<=1 at the edge; cooldown<=MIN_CPU_CYCLES; -> CPU.
  - cpu_hold drops in the cycle dbg_ack is high.
- dbg_ack is high exactly one cycle.
- If dbg_req is still 1 in the cycle after ack, it is a new request subject to cooldown.
- Latency: dbg_req first seen in cycle 0 with CPU idle -> DACC in cycle 2, dbg_ack in cycle 4 (minimum). Each extra cycle of cpu_req=1 in HOLD adds 1.
- Debug inputs are don't-care after capture. Changes during HOLD..DRESP have no effect.
- cpu_rdata=mem_in in all states; the CPU must not consume it while held.
- Cooldown counter width: $clog2(MIN_CPU_CYCLES+1), minimum 1 bit. No wrap; saturates at 0.
- mem_out is 0 when mem_write=0 in HOLD/DRESP, to avoid X propagation.

Test Plan:
- Passthrough: dbg_req=0, CPU writes 0xBEEF to addr 0x0010 with we=2'b11, then reads it -> mem_write=2'b11 in the write cycle; cpu_rdata=0xBEEF the cycle after the read; cpu_hold stays 0.
- Debug read, idle CPU: mem[0x1234]=0xA55A, dbg_req with dbg_we=0 in cycle 0 -> cpu_hold=1 in cycles 1-3, mem_en=1 with addr 0x1234 only in cycle 2, dbg_ack=1 and dbg_rdata=0xA55A in cycle 4.
- Debug write vs busy CPU: cpu_req=1 for cycles 0-5, dbg write 0x00FF we=2'b01 to 0x0002 -> HOLD through cycle 6, DACC in cycle 7 with mem_write=2'b01, dbg_ack in cycle 9; CPU address never driven while held.
- Cooldown: MIN_CPU_CYCLES=4, dbg_req held high continuously -> consecutive dbg_ack pulses exactly 9 cycles apart (4 cooldown + 5 access), cpu_hold low in at least 4 cycles between pulses.
- Simultaneous: cpu_req=1, cpu_we=2'b10 and dbg_req rise in the same cycle -> CPU write occurs that cycle; hold asserts next cycle; debug access follows the CPU gap.
- Reset mid-access: assert reset during DACC -> next cycle state CPU, cpu_hold=0, no dbg_ack ever; mem_en=0 during the reset cycle.

Source files
------------

// File: rtl/cdm16_mem_arbiter_if.sv
// cdm16_mem_arbiter_if: CPU, debug and BRAM signal bundle for the cdm16 memory arbiter
//   slave  : arbiter side (takes cpu_*/dbg_* requests and mem_in, drives BRAM and responses)
//   master : environment side (CPU, debug port and BRAM model)
interface cdm16_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [1:0]        cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hold;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [1:0]        dbg_we;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_out;
  logic [DATA_W-1:0] mem_in;
  logic              mem_en;
  logic [1:0]        mem_write;
  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata, dbg_req, dbg_addr, dbg_we, dbg_wdata, mem_in,
    output cpu_rdata, cpu_hold, dbg_ack, dbg_rdata, mem_addr, mem_out, mem_en, mem_write
  );
  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_wdata, dbg_req, dbg_addr, dbg_we, dbg_wdata, mem_in,
    input  cpu_rdata, cpu_hold, dbg_ack, dbg_rdata, mem_addr, mem_out, mem_en, mem_write
  );
endinterface

// File: rtl/cdm16_mem_arbiter.sv
// cdm16_mem_arbiter: shares one single-port BRAM between the cdm16 CPU and a debug/loader port
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : cpu_* CPU side, dbg_* debug side, mem_* BRAM side
module cdm16_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int MIN_CPU_CYCLES = 4
) (
  input logic clock,
  input logic reset,
  cdm16_mem_arbiter_if.slave bus
);
  localparam int CW = MIN_CPU_CYCLES > 0 ? $clog2(MIN_CPU_CYCLES + 1) : 1;
  typedef enum logic [1:0] {CPU, HOLD, DACC, DRESP} state_t;
  state_t            state;
  logic [CW-1:0]     cooldown;
  logic [ADDR_W-1:0] cap_addr;
  logic [1:0]        cap_we;
  logic [DATA_W-1:0] cap_wdata;
  logic              hold_r;
  logic              ack_r;
  logic [DATA_W-1:0] rdata_r;
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CPU;
      cooldown  <= '0;
      cap_addr  <= '0;
      cap_we    <= '0;
      cap_wdata <= '0;
      hold_r    <= 1'b0;
      ack_r     <= 1'b0;
      rdata_r   <= '0;
    end else begin
      ack_r <= 1'b0;
      case (state)
        CPU:
          // the ack cycle still sees the finished request's dbg_req: it neither counts down nor captures
          if (!ack_r) begin
            if (cooldown != '0) cooldown <= cooldown - 1'b1;
            else if (bus.dbg_req) begin
              cap_addr  <= bus.dbg_addr;
              cap_we    <= bus.dbg_we;
              cap_wdata <= bus.dbg_wdata;
              hold_r    <= 1'b1;
              state     <= HOLD;
            end
          end
        HOLD: if (!bus.cpu_req) state <= DACC;
        DACC: state <= DRESP;
        DRESP: begin
          if (cap_we == 2'b00) rdata_r <= bus.mem_in;
          ack_r    <= 1'b1;
          hold_r   <= 1'b0;
          cooldown <= CW'(MIN_CPU_CYCLES);
          state    <= CPU;
        end
        default: state <= CPU;
      endcase
    end
  end
  assign bus.mem_en    = !reset && (state == CPU ? bus.cpu_req : state == DACC);
  assign bus.mem_write = reset ? 2'b00 : state == CPU ? bus.cpu_we & {2{bus.cpu_req}} : state == DACC ? cap_we : 2'b00;
  assign bus.mem_addr  = state == CPU ? bus.cpu_addr : cap_addr;
  assign bus.mem_out   = state == CPU ? bus.cpu_wdata : state == DACC ? cap_wdata : '0;
  assign bus.cpu_rdata = bus.mem_in;
  assign bus.cpu_hold  = hold_r;
  assign bus.dbg_ack   = ack_r;
  assign bus.dbg_rdata = rdata_r;
endmodule

// File: tb/tb_cdm16_mem_arbiter.sv
// tb_cdm16_mem_arbiter: directed and randomized self-checking bench for cdm16_mem_arbiter
module tb_cdm16_mem_arbiter;
  localparam int MIN = 4;
  localparam int N = 600;
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int passed = 0;
  logic [15:0] mem [0:32767];
  cdm16_mem_arbiter_if bus ();
  cdm16_mem_arbiter #(.ADDR_W(15), .DATA_W(16), .MIN_CPU_CYCLES(MIN)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_write[0]) mem[bus.mem_addr][7:0] <= bus.mem_out[7:0];
      if (bus.mem_write[1]) mem[bus.mem_addr][15:8] <= bus.mem_out[15:8];
      bus.mem_in <= mem[bus.mem_addr];
    end
  end
  bit          creq [N];
  logic [1:0]  cwe [N];
  logic [2:0]  caddr [N];
  logic [15:0] cwd [N];
  bit          dreq [N];
  logic [14:0] daddr [N];
  logic [1:0]  dwe [N];
  logic [15:0] dwd [N];
  bit          xhold [N];
  bit          xack [N];
  bit          xen [N];
  logic [1:0]  xwr [N];
  bit          xrd_chk [N];
  logic [15:0] xrd [N];
  bit          isd [N];
  logic [2:0]  op_addr [N];
  logic [1:0]  op_we [N];
  logic [15:0] op_wd [N];
  logic [15:0] ref_mem [8];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    bus.cpu_req = 1'b0;
    bus.cpu_we = 2'b00;
    bus.dbg_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 2'b11;
    bus.cpu_addr = 15'h0007;
    bus.cpu_wdata = 16'h1111;
    bus.dbg_req = 1'b0;
    bus.dbg_addr = '0;
    bus.dbg_we = '0;
    bus.dbg_wdata = '0;
    tick();
    tick();
    #2;
    checks++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en got=%0h exp=0", bus.mem_en); else passed++;
    checks++; if (bus.mem_write !== 2'b00) $display("FAIL rst_mem_write got=%0h exp=0", bus.mem_write); else passed++;
    checks++; if (bus.cpu_hold !== 1'b0) $display("FAIL rst_hold got=%0h exp=0", bus.cpu_hold); else passed++;
    checks++; if (bus.dbg_ack !== 1'b0) $display("FAIL rst_ack got=%0h exp=0", bus.dbg_ack); else passed++;
    checks++; if (bus.dbg_rdata !== 16'h0) $display("FAIL rst_rdata got=%0h exp=0", bus.dbg_rdata); else passed++;
    tick();
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_passthrough;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 15'h0010;
    bus.cpu_we = 2'b11;
    bus.cpu_wdata = 16'hBEEF;
    #2;
    checks++; if (bus.mem_write !== 2'b11 || bus.mem_en !== 1'b1) $display("FAIL pt_write got=%0h/%0h exp=3/1", bus.mem_write, bus.mem_en); else passed++;
    checks++; if (bus.mem_addr !== 15'h0010 || bus.mem_out !== 16'hBEEF) $display("FAIL pt_addr_data got=%0h/%0h exp=10/beef", bus.mem_addr, bus.mem_out); else passed++;
    tick();
    bus.cpu_we = 2'b00;
    #2;
    checks++; if (bus.mem_write !== 2'b00 || bus.cpu_hold !== 1'b0) $display("FAIL pt_read got=%0h/%0h exp=0/0", bus.mem_write, bus.cpu_hold); else passed++;
    tick();
    bus.cpu_req = 1'b0;
    #2;
    checks++; if (bus.cpu_rdata !== 16'hBEEF) $display("FAIL pt_rdata got=%0h exp=beef", bus.cpu_rdata); else passed++;
    checks++; if (bus.cpu_hold !== 1'b0) $display("FAIL pt_hold got=%0h exp=0", bus.cpu_hold); else passed++;
    tick();
  endtask

  task automatic test_dbg_read;
    mem[15'h1234] = 16'hA55A;
    for (int k = 0; k <= 4; k++) begin
      bus.cpu_req = 1'b0;
      bus.dbg_req = 1'b1;
      bus.dbg_addr = k == 0 ? 15'h1234 : 15'($urandom);
      bus.dbg_we = k == 0 ? 2'b00 : 2'($urandom);
      bus.dbg_wdata = 16'($urandom);
      #2;
      checks++; if (bus.cpu_hold !== (k >= 1 && k <= 3)) $display("FAIL rd_hold k=%0d got=%0h", k, bus.cpu_hold); else passed++;
      checks++; if (bus.mem_en !== (k == 2)) $display("FAIL rd_en k=%0d got=%0h", k, bus.mem_en); else passed++;
      checks++; if (bus.dbg_ack !== (k == 4)) $display("FAIL rd_ack k=%0d got=%0h", k, bus.dbg_ack); else passed++;
      if (k == 2) begin
        checks++; if (bus.mem_addr !== 15'h1234 || bus.mem_write !== 2'b00) $display("FAIL rd_dacc got=%0h/%0h exp=1234/0", bus.mem_addr, bus.mem_write); else passed++;
      end
      if (k == 4) begin
        checks++; if (bus.dbg_rdata !== 16'hA55A) $display("FAIL rd_data got=%0h exp=a55a", bus.dbg_rdata); else passed++;
      end
      tick();
    end
    idle(8);
  endtask

  task automatic test_dbg_write_busy;
    mem[15'h0002] = 16'h1234;
    for (int k = 0; k <= 9; k++) begin
      bus.cpu_req = k <= 5;
      bus.cpu_addr = 15'h0100;
      bus.cpu_we = 2'b00;
      bus.dbg_req = 1'b1;
      bus.dbg_addr = k == 0 ? 15'h0002 : 15'($urandom);
      bus.dbg_we = k == 0 ? 2'b01 : 2'($urandom);
      bus.dbg_wdata = k == 0 ? 16'h00FF : 16'($urandom);
      #2;
      checks++; if (bus.cpu_hold !== (k >= 1 && k <= 8)) $display("FAIL wr_hold k=%0d got=%0h", k, bus.cpu_hold); else passed++;
      checks++; if (bus.mem_en !== (k == 0 || k == 7)) $display("FAIL wr_en k=%0d got=%0h", k, bus.mem_en); else passed++;
      checks++; if (bus.dbg_ack !== (k == 9)) $display("FAIL wr_ack k=%0d got=%0h", k, bus.dbg_ack); else passed++;
      if (k == 7) begin
        checks++; if (bus.mem_write !== 2'b01 || bus.mem_addr !== 15'h0002 || bus.mem_out !== 16'h00FF)
          $display("FAIL wr_dacc got=%0h/%0h/%0h exp=1/2/ff", bus.mem_write, bus.mem_addr, bus.mem_out); else passed++;
      end else if (k >= 1 && k <= 8) begin
        checks++; if (bus.mem_write !== 2'b00) $display("FAIL wr_held_write k=%0d got=%0h exp=0", k, bus.mem_write); else passed++;
      end
      tick();
    end
    idle(8);
    checks++; if (mem[15'h0002] !== 16'h12FF) $display("FAIL wr_result got=%0h exp=12ff", mem[15'h0002]); else passed++;
  endtask

  task automatic test_cooldown;
    int low = 0;
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 15'h0010;
    bus.dbg_we = 2'b00;
    for (int k = 0; k <= 22; k++) begin
      bus.cpu_req = 1'b0;
      #2;
      checks++; if (bus.dbg_ack !== (k % 9 == 4)) $display("FAIL cd_ack k=%0d got=%0h", k, bus.dbg_ack); else passed++;
      if (k >= 5 && k <= 12 && bus.cpu_hold === 1'b0) low++;
      tick();
    end
    bus.dbg_req = 1'b0;
    checks++; if (low < 4) $display("FAIL cd_hold_low got=%0d exp>=4", low); else passed++;
    idle(8);
  endtask

  task automatic test_simultaneous;
    mem[15'h0020] = 16'h11CD;
    for (int k = 0; k <= 5; k++) begin
      bus.cpu_req = k <= 1;
      bus.cpu_addr = 15'h0020;
      bus.cpu_we = k == 0 ? 2'b10 : 2'b00;
      bus.cpu_wdata = 16'hAB00;
      bus.dbg_req = 1'b1;
      bus.dbg_addr = 15'h0020;
      bus.dbg_we = 2'b00;
      #2;
      checks++; if (bus.cpu_hold !== (k >= 1 && k <= 4)) $display("FAIL sim_hold k=%0d got=%0h", k, bus.cpu_hold); else passed++;
      checks++; if (bus.mem_en !== (k == 0 || k == 3)) $display("FAIL sim_en k=%0d got=%0h", k, bus.mem_en); else passed++;
      if (k == 0) begin
        checks++; if (bus.mem_write !== 2'b10) $display("FAIL sim_cpu_write got=%0h exp=2", bus.mem_write); else passed++;
      end
      if (k == 5) begin
        checks++; if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 16'hABCD) $display("FAIL sim_result got=%0h/%0h exp=1/abcd", bus.dbg_ack, bus.dbg_rdata); else passed++;
      end
      tick();
    end
    idle(8);
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k <= 12; k++) begin
      reset = k == 2;
      bus.dbg_req = k <= 2;
      bus.dbg_addr = 15'h0030;
      bus.dbg_we = 2'b00;
      bus.cpu_req = k == 3;
      bus.cpu_addr = 15'h0040;
      bus.cpu_we = 2'b00;
      #2;
      if (k == 1) begin
        checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL rm_hold got=%0h exp=1", bus.cpu_hold); else passed++;
      end
      if (k == 2) begin
        checks++; if (bus.mem_en !== 1'b0) $display("FAIL rm_en_in_reset got=%0h exp=0", bus.mem_en); else passed++;
      end
      if (k == 3) begin
        checks++; if (bus.cpu_hold !== 1'b0 || bus.mem_en !== 1'b1) $display("FAIL rm_after got=%0h/%0h exp=0/1", bus.cpu_hold, bus.mem_en); else passed++;
        checks++; if (bus.dbg_rdata !== 16'h0) $display("FAIL rm_rdata got=%0h exp=0", bus.dbg_rdata); else passed++;
      end
      if (k >= 3) begin
        checks++; if (bus.dbg_ack !== 1'b0) $display("FAIL rm_no_ack k=%0d got=%0h", k, bus.dbg_ack); else passed++;
      end
      tick();
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_random;
    int prev_ack, t, c, g, a, m;
    for (int k = 0; k < N; k++) begin
      creq[k] = $urandom_range(0, 99) < 55;
      cwe[k] = 2'($urandom);
      caddr[k] = 3'($urandom);
      cwd[k] = 16'($urandom);
      dreq[k] = 1'b0;
      daddr[k] = 15'($urandom);
      dwe[k] = 2'($urandom);
      dwd[k] = 16'($urandom);
      xhold[k] = 1'b0;
      xack[k] = 1'b0;
      xrd_chk[k] = 1'b0;
      isd[k] = 1'b0;
    end
    // Transaction-level timing: capture once requested and out of cooldown,
    // access one cycle after the first idle CPU cycle in hold, ack two cycles later.
    prev_ack = -100;
    t = 5 + int'($urandom_range(0, 4));
    forever begin
      c = t > prev_ack + 1 + MIN ? t : prev_ack + 1 + MIN;
      g = c + 1;
      while (g < N && creq[g]) g++;
      a = g + 3;
      if (a >= N - 2) break;
      isd[g + 1] = 1'b1;
      op_addr[g + 1] = 3'($urandom);
      op_we[g + 1] = $urandom_range(0, 1) ? 2'b00 : 2'($urandom);
      op_wd[g + 1] = 16'($urandom);
      for (int k = t; k <= a; k++) dreq[k] = 1'b1;
      for (int k = t; k <= c; k++) begin
        daddr[k] = {12'b0, op_addr[g + 1]};
        dwe[k] = op_we[g + 1];
        dwd[k] = op_wd[g + 1];
      end
      for (int k = c + 1; k < a; k++) xhold[k] = 1'b1;
      xack[a] = 1'b1;
      prev_ack = a;
      t = a + 1 + int'($urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 16'($urandom);
      mem[i] = ref_mem[i];
    end
    for (int k = 0; k < N; k++) begin
      m = 0;
      xen[k] = 1'b0;
      xwr[k] = 2'b00;
      if (isd[k]) begin
        m = op_addr[k];
        xen[k] = 1'b1;
        xwr[k] = op_we[k];
        if (op_we[k] == 2'b00) begin
          xrd_chk[k + 2] = 1'b1;
          xrd[k + 2] = ref_mem[m];
        end
        if (op_we[k][0]) ref_mem[m][7:0] = op_wd[k][7:0];
        if (op_we[k][1]) ref_mem[m][15:8] = op_wd[k][15:8];
      end else if (!xhold[k] && creq[k]) begin
        m = caddr[k];
        xen[k] = 1'b1;
        xwr[k] = cwe[k];
        if (cwe[k][0]) ref_mem[m][7:0] = cwd[k][7:0];
        if (cwe[k][1]) ref_mem[m][15:8] = cwd[k][15:8];
      end
    end
    for (int k = 0; k < N; k++) begin
      bus.cpu_req = creq[k];
      bus.cpu_addr = {12'b0, caddr[k]};
      bus.cpu_we = cwe[k];
      bus.cpu_wdata = cwd[k];
      bus.dbg_req = dreq[k];
      bus.dbg_addr = daddr[k];
      bus.dbg_we = dwe[k];
      bus.dbg_wdata = dwd[k];
      #2;
      checks++; if (bus.cpu_hold !== xhold[k]) $display("FAIL rnd_hold k=%0d got=%0h exp=%0h", k, bus.cpu_hold, xhold[k]); else passed++;
      checks++; if (bus.dbg_ack !== xack[k]) $display("FAIL rnd_ack k=%0d got=%0h exp=%0h", k, bus.dbg_ack, xack[k]); else passed++;
      checks++; if (bus.mem_en !== xen[k] || bus.mem_write !== xwr[k])
        $display("FAIL rnd_mem k=%0d got=%0h/%0h exp=%0h/%0h", k, bus.mem_en, bus.mem_write, xen[k], xwr[k]); else passed++;
      if (xrd_chk[k]) begin
        checks++; if (bus.dbg_rdata !== xrd[k]) $display("FAIL rnd_rdata k=%0d got=%0h exp=%0h", k, bus.dbg_rdata, xrd[k]); else passed++;
      end
      tick();
    end
    idle(1);
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem[i] !== ref_mem[i]) $display("FAIL rnd_final addr=%0d got=%0h exp=%0h", i, mem[i], ref_mem[i]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_dbg_read();
    test_dbg_write_busy();
    test_cooldown();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
